// File: rtl/cayde_pkg.sv
// Shared widths and load funct3 encodings for the cayde writeback stage.
package cayde_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

endpackage

// File: rtl/cayde_load_align.sv
// Combinational load aligner: selects byte/halfword/word from the raw memory
// word, sign/zero extends it and flags misaligned or illegal loads.
module cayde_load_align
    import cayde_pkg::*;
#(
    parameter int unsigned XLEN = cayde_pkg::XLEN
) (
    input  logic [XLEN-1:0] data_in,
    input  logic [2:0]      funct3_in,
    input  logic [1:0]      addr_lo_in,
    output logic [XLEN-1:0] data_out,
    output logic            err_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_in)
            2'd0:    byte_sel = data_in[7:0];
            2'd1:    byte_sel = data_in[15:8];
            2'd2:    byte_sel = data_in[23:16];
            default: byte_sel = data_in[31:24];
        endcase
        half_sel = addr_lo_in[1] ? data_in[31:16] : data_in[15:0];

        data_out = '0;
        err_out  = 1'b0;
        case (funct3_in)
            LB:  data_out = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU: data_out = {{(XLEN-8){1'b0}}, byte_sel};
            LH: begin
                if (addr_lo_in[0]) err_out = 1'b1;
                else               data_out = {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            LHU: begin
                if (addr_lo_in[0]) err_out = 1'b1;
                else               data_out = {{(XLEN-16){1'b0}}, half_sel};
            end
            LW: begin
                if (addr_lo_in != 2'b00) err_out = 1'b1;
                else                     data_out = data_in;
            end
            default: err_out = 1'b1;
        endcase
    end

endmodule

// File: rtl/cayde_writeback.sv
// Writeback stage: LSU/ALU arbitration with anti-starvation, load alignment,
// pending-load scoreboard and registered register-file write port.
// Optional forwarding outputs are enabled by defining CAYDE_WB_BYPASS_EN.
module cayde_writeback
    import cayde_pkg::*;
#(
    parameter int unsigned XLEN         = cayde_pkg::XLEN,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid_in,
    output logic                  alu_ready_out,
    input  logic [REG_ADDR_W-1:0] alu_rd_in,
    input  logic [XLEN-1:0]       alu_data_in,
    input  logic                  lsu_valid_in,
    output logic                  lsu_ready_out,
    input  logic [REG_ADDR_W-1:0] lsu_rd_in,
    input  logic [XLEN-1:0]       lsu_data_in,
    input  logic [2:0]            lsu_funct3_in,
    input  logic [1:0]            lsu_addr_lo_in,
    input  logic                  issue_valid_in,
    input  logic [REG_ADDR_W-1:0] issue_rd_in,
    input  logic [REG_ADDR_W-1:0] chk_rs1_in,
    input  logic [REG_ADDR_W-1:0] chk_rs2_in,
    output logic                  stall_out,
    output logic [REG_ADDR_W-1:0] waddr_out,
    output logic [XLEN-1:0]       wdata_out,
    output logic                  wen_out,
    output logic                  load_err_out,
`ifdef CAYDE_WB_BYPASS_EN
    output logic                  fwd1_hit_out,
    output logic                  fwd2_hit_out,
    output logic [XLEN-1:0]       fwd_data_out,
`endif
    output logic [31:0]           busy_out
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  load_err_q, load_err_d;
    logic [31:0]           busy_q, busy_d;

    logic            starve_hit;
    logic            alu_acc, lsu_acc;
    logic [XLEN-1:0] align_data;
    logic            align_err;
    logic            hit1, hit2;

    cayde_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .data_in    (lsu_data_in),
        .funct3_in  (lsu_funct3_in),
        .addr_lo_in (lsu_addr_lo_in),
        .data_out   (align_data),
        .err_out    (align_err)
    );

    // Readies are forced low while reset is asserted.
    always_comb begin
        starve_hit    = (starve_q == CNT_W'(STARVE_LIMIT));
        alu_ready_out = rst & (starve_hit | ~lsu_valid_in);
        lsu_ready_out = rst & ~starve_hit;
        alu_acc       = alu_valid_in & alu_ready_out;
        lsu_acc       = lsu_valid_in & lsu_ready_out;
    end

    always_comb begin
        starve_d   = (!alu_valid_in || alu_acc) ? '0 : starve_q + CNT_W'(1);
        wen_d      = 1'b0;
        load_err_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (alu_acc) begin
            waddr_d = alu_rd_in;
            wdata_d = alu_data_in;
            wen_d   = (alu_rd_in != '0);
        end else if (lsu_acc) begin
            if (align_err) begin
                load_err_d = 1'b1;
            end else begin
                waddr_d = lsu_rd_in;
                wdata_d = align_data;
                wen_d   = (lsu_rd_in != '0);
            end
        end

        // Clear first so a same-cycle issue of the same rd wins.
        busy_d = busy_q;
        if (lsu_acc) busy_d[lsu_rd_in] = 1'b0;
        if (issue_valid_in && issue_rd_in != '0) busy_d[issue_rd_in] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q   <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            load_err_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            load_err_q <= load_err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        hit1 = wen_q && (chk_rs1_in != '0) && (waddr_q == chk_rs1_in);
        hit2 = wen_q && (chk_rs2_in != '0) && (waddr_q == chk_rs2_in);
`ifdef CAYDE_WB_BYPASS_EN
        stall_out    = busy_q[chk_rs1_in] | busy_q[chk_rs2_in];
        fwd1_hit_out = hit1;
        fwd2_hit_out = hit2;
        fwd_data_out = wdata_q;
`else
        stall_out    = busy_q[chk_rs1_in] | busy_q[chk_rs2_in] | hit1 | hit2;
`endif
    end

    assign waddr_out    = waddr_q;
    assign wdata_out    = wdata_q;
    assign wen_out      = wen_q;
    assign load_err_out = load_err_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_cayde_writeback.sv
// Scoreboard bench for cayde_writeback: expected writes are queued at
// acceptance and compared one cycle later at the register-file port.
module tb_cayde_writeback;

    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_in, alu_ready_out;
    logic [4:0]  alu_rd_in;
    logic [31:0] alu_data_in;
    logic        lsu_valid_in, lsu_ready_out;
    logic [4:0]  lsu_rd_in;
    logic [31:0] lsu_data_in;
    logic [2:0]  lsu_funct3_in;
    logic [1:0]  lsu_addr_lo_in;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_in, chk_rs1_in, chk_rs2_in;
    logic        stall_out;
    logic [4:0]  waddr_out;
    logic [31:0] wdata_out;
    logic        wen_out, load_err_out;
    logic [31:0] busy_out;
`ifdef CAYDE_WB_BYPASS_EN
    logic        fwd1_hit_out, fwd2_hit_out;
    logic [31:0] fwd_data_out;
`endif

    cayde_writeback #(
        .XLEN         (32),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid_in   (alu_valid_in),
        .alu_ready_out  (alu_ready_out),
        .alu_rd_in      (alu_rd_in),
        .alu_data_in    (alu_data_in),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_ready_out  (lsu_ready_out),
        .lsu_rd_in      (lsu_rd_in),
        .lsu_data_in    (lsu_data_in),
        .lsu_funct3_in  (lsu_funct3_in),
        .lsu_addr_lo_in (lsu_addr_lo_in),
        .issue_valid_in (issue_valid_in),
        .issue_rd_in    (issue_rd_in),
        .chk_rs1_in     (chk_rs1_in),
        .chk_rs2_in     (chk_rs2_in),
        .stall_out      (stall_out),
        .waddr_out      (waddr_out),
        .wdata_out      (wdata_out),
        .wen_out        (wen_out),
        .load_err_out   (load_err_out),
`ifdef CAYDE_WB_BYPASS_EN
        .fwd1_hit_out   (fwd1_hit_out),
        .fwd2_hit_out   (fwd2_hit_out),
        .fwd_data_out   (fwd_data_out),
`endif
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_starve;
    logic [31:0] m_busy;
    logic        m_hold;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void tb_align(input logic [31:0] raw, input logic [2:0] f3,
                                     input logic [1:0] lo, output logic [31:0] d,
                                     output logic e);
        logic [31:0] sh;
        sh = raw >> (8 * lo);
        d  = 32'h0;
        e  = 1'b0;
        case (f3)
            3'b000: d = {{24{sh[7]}}, sh[7:0]};
            3'b100: d = {24'h0, sh[7:0]};
            3'b001: if (lo[0]) e = 1'b1; else d = {{16{sh[15]}}, sh[15:0]};
            3'b101: if (lo[0]) e = 1'b1; else d = {16'h0, sh[15:0]};
            3'b010: if (lo != 2'b00) e = 1'b1; else d = raw;
            default: e = 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_starve = 0;
        m_busy   = 32'h0;
        m_hold   = 1'b1;
        m_waddr  = 5'd0;
        m_wdata  = 32'h0;
        sb_q.push_back('{wen: 1'b0, err: 1'b0, rd: 5'd0, data: 32'h0});
    endtask

    task automatic idle();
        alu_valid_in   = 1'b0;
        lsu_valid_in   = 1'b0;
        issue_valid_in = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid_in = 1'b1;
        alu_rd_in    = rd;
        alu_data_in  = data;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data,
                             input logic [2:0] f3, input logic [1:0] lo);
        lsu_valid_in   = 1'b1;
        lsu_rd_in      = rd;
        lsu_data_in    = data;
        lsu_funct3_in  = f3;
        lsu_addr_lo_in = lo;
    endtask

    // Called at posedge+1 with this cycle's inputs driven; returns at next posedge+1.
    task automatic step();
        exp_t        e, n;
        logic        hit, ar, lr, aacc, lacc, st;
        logic [31:0] ld;
        logic        le;
        #1;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("wen", wen_out, e.wen);
            check_eq("load_err", load_err_out, e.err);
            if (m_hold) begin
                check_eq("waddr", waddr_out, m_waddr);
                check_eq("wdata", wdata_out, m_wdata);
            end
            st = m_busy[chk_rs1_in] | m_busy[chk_rs2_in];
`ifndef CAYDE_WB_BYPASS_EN
            st = st | (e.wen && ((chk_rs1_in != 0 && m_waddr == chk_rs1_in) ||
                                 (chk_rs2_in != 0 && m_waddr == chk_rs2_in)));
`endif
            check_eq("stall", stall_out, st);
        end
        check_eq("busy", busy_out, m_busy);

        hit = (m_starve == STARVE_LIMIT);
        ar  = hit || !lsu_valid_in;
        lr  = !hit;
        check_eq("alu_ready", alu_ready_out, ar);
        check_eq("lsu_ready", lsu_ready_out, lr);
        aacc = alu_valid_in && ar;
        lacc = lsu_valid_in && lr && !aacc;

        n = '{wen: 1'b0, err: 1'b0, rd: 5'd0, data: 32'h0};
        if (aacc) begin
            n.wen = (alu_rd_in != 0); n.rd = alu_rd_in; n.data = alu_data_in;
        end else if (lacc) begin
            tb_align(lsu_data_in, lsu_funct3_in, lsu_addr_lo_in, ld, le);
            n.err = le;
            if (!le) begin
                n.wen = (lsu_rd_in != 0); n.rd = lsu_rd_in; n.data = ld;
            end
        end
        if (n.wen) begin
            m_hold = 1'b1; m_waddr = n.rd; m_wdata = n.data;
        end else if (aacc || lacc) begin
            m_hold = 1'b0;
        end
        sb_q.push_back(n);

        if (lacc) m_busy[lsu_rd_in] = 1'b0;
        if (issue_valid_in && issue_rd_in != 0) m_busy[issue_rd_in] = 1'b1;
        m_starve = (!alu_valid_in || aacc) ? 0 : m_starve + 1;

        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] grant_pat;
        rst = 1'b1;
        idle();
        alu_rd_in = '0; alu_data_in = '0;
        lsu_rd_in = '0; lsu_data_in = '0; lsu_funct3_in = '0; lsu_addr_lo_in = '0;
        issue_rd_in = '0; chk_rs1_in = '0; chk_rs2_in = '0;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_wen", wen_out, 0);
        check_eq("rst_waddr", waddr_out, 0);
        check_eq("rst_wdata", wdata_out, 0);
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_alu_ready", alu_ready_out, 0);
        check_eq("rst_lsu_ready", lsu_ready_out, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        drive_alu(5'd5, 32'hDEADBEEF);
        step();
        check_eq("alu_wen", wen_out, 1);
        check_eq("alu_waddr", waddr_out, 5);
        check_eq("alu_wdata", wdata_out, 32'hDEADBEEF);
        idle();
        step();
        check_eq("hold_wen", wen_out, 0);
        check_eq("hold_waddr", waddr_out, 5);

        drive_lsu(5'd10, 32'h80FF0000, 3'b000, 2'd2);
        step();
        check_eq("lb_data", wdata_out, 32'hFFFFFFFF);
        drive_lsu(5'd11, 32'h80FF0000, 3'b101, 2'd2);
        step();
        check_eq("lhu_data", wdata_out, 32'h000080FF);
        drive_lsu(5'd12, 32'h80FF0000, 3'b001, 2'd1);
        step();
        check_eq("lh_mis_err", load_err_out, 1);
        check_eq("lh_mis_wen", wen_out, 0);
        idle();
        step();
        check_eq("err_pulse_end", load_err_out, 0);

        for (int i = 0; i < 32; i++) begin
            drive_lsu(5'(1 + (i % 31)), $urandom, 3'(i / 4), 2'(i % 4));
            step();
        end
        idle();
        step();

        grant_pat = 6'b010000;
        for (int i = 0; i < 6; i++) begin
            drive_alu(5'd20, 32'hA0 + 32'(i));
            drive_lsu(5'd21, 32'(i), 3'b010, 2'd0);
            #1 check_eq("starve_alu_rdy", alu_ready_out, grant_pat[i]);
            step();
        end
        idle();
        step();

        issue_valid_in = 1'b1; issue_rd_in = 5'd7; chk_rs1_in = 5'd7;
        step();
        check_eq("stall_busy7", stall_out, 1);
        issue_valid_in = 1'b0;
        step();
        drive_lsu(5'd7, 32'h11111111, 3'b010, 2'd0);
        issue_valid_in = 1'b1;
        step();
        check_eq("reissue_busy7", busy_out[7], 1);
        issue_valid_in = 1'b0;
        step();
        check_eq("clear_busy7", busy_out[7], 0);
        idle();
        chk_rs1_in = 5'd0;
        step();
        check_eq("stall_clear", stall_out, 0);
        issue_valid_in = 1'b1; issue_rd_in = 5'd9; chk_rs2_in = 5'd9;
        step();
        check_eq("stall_rs2", stall_out, 1);
        issue_valid_in = 1'b0;
        drive_lsu(5'd9, 32'h22222222, 3'b010, 2'd0);
        step();
        idle();
        chk_rs2_in = 5'd0;
        step();

        drive_alu(5'd0, 32'h1234);
        step();
        check_eq("x0_wen", wen_out, 0);
        idle();
        issue_valid_in = 1'b1; issue_rd_in = 5'd0;
        step();
        check_eq("x0_busy", busy_out, 0);
        issue_valid_in = 1'b0;

        issue_valid_in = 1'b1; issue_rd_in = 5'd3;
        drive_alu(5'd9, 32'hCAFEF00D);
        step();
        check_eq("pre_rst_wen", wen_out, 1);
        check_eq("pre_rst_busy3", busy_out[3], 1);
        idle();
        #1 rst = 1'b0;
        #1;
        check_eq("arst_wen", wen_out, 0);
        check_eq("arst_waddr", waddr_out, 0);
        check_eq("arst_wdata", wdata_out, 0);
        check_eq("arst_err", load_err_out, 0);
        check_eq("arst_busy", busy_out, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        drive_alu(5'd6, 32'h600D600D);
        step();
        idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cayde_writeback.md
# cayde_writeback

Writeback stage for the cayde RISC-V core and sole driver of the register file write port (`waddr`/`wdata`/`wen`). It accepts results from the ALU and the load/store unit over valid/ready handshakes, and arbitrates them with LSU priority plus an anti-starvation counter. Load data is aligned and extended, and the result is registered into a one-cycle output stage feeding the register file. A pending-load scoreboard drives the decode-stage stall.

## Interface
- `XLEN`, 32, data width
- `STARVE_LIMIT`, 4, consecutive ALU-blocked cycles before the ALU is granted priority for one cycle
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `alu_valid_in` in 1 / `alu_ready_out` out 1: ALU result handshake
- `alu_rd_in` in 5 / `alu_data_in` in XLEN: ALU destination and result
- `lsu_valid_in` in 1 / `lsu_ready_out` out 1: load result handshake
- `lsu_rd_in` in 5 / `lsu_data_in` in XLEN: load destination and raw aligned memory word
- `lsu_funct3_in` in 3 / `lsu_addr_lo_in` in 2: load type and byte offset
- `issue_valid_in` in 1 / `issue_rd_in` in 5: load issued by decode; marks rd busy
- `chk_rs1_in` in 5 / `chk_rs2_in` in 5: source registers of the instruction in decode
- `stall_out` out 1: decode must hold
- `waddr_out` out 5 / `wdata_out` out XLEN / `wen_out` out 1: register file write port, registered
- `load_err_out` out 1: one-cycle pulse on misaligned load or illegal funct3
- `busy_out` out 32: scoreboard bits; bit 0 is always 0

## Operation
- **Arbitration:**
  - Default: LSU wins. `lsu_ready_out`=1 and `alu_ready_out`=!`lsu_valid_in`.
  - Starve counter: increments each cycle with `alu_valid_in`=1 and no ALU acceptance. Clears on ALU acceptance or when `alu_valid_in`=0.
  - At counter == STARVE_LIMIT the ALU is granted: `alu_ready_out`=1, `lsu_ready_out`=0. The counter then clears.
- **Load alignment** (`lsu_funct3_in`):
  - 000 LB / 100 LBU: byte `addr_lo`, sign- or zero-extended.
  - 001 LH / 101 LHU: halfword `addr_lo[1]`, sign- or zero-extended. `addr_lo[0]`=1 is misaligned.
  - 010 LW: requires `addr_lo`=00.
  - 011, 11x: illegal.
- **Errors:** on a misaligned or illegal load, there is no write. The busy bit for rd is still cleared, and `load_err_out` pulses in the output-stage cycle.
- **x0:** rd=0 is accepted normally, but `wen_out` stays 0.
- **Scoreboard:**
  - `issue_valid_in` with rd≠0 sets busy[rd].
  - An accepted LSU result clears busy[rd].
  - Set and clear of the same rd in one cycle: set wins.
  - Issue with rd=0 is ignored.
- **Stall:** `stall_out` = busy[rs1] | busy[rs2] | output-stage hazard (see Configuration). Combinational.

## Timing
- Latency: one cycle. A handshake accepted at edge N drives `wen_out`/`waddr_out`/`wdata_out` during cycle N+1; the register file commits at edge N+1.
- `wen_out` is high for exactly one cycle per accepted, non-x0, non-error result.
- At most one acceptance per cycle. When neither source is accepted, `wen_out`=0 and `waddr_out`/`wdata_out` hold their values.
- Reset asserted (asynchronous) clears everything immediately:
  - outputs: `wen_out`=0, `waddr_out`=0, `wdata_out`=0, `load_err_out`=0, `busy_out`=0;
  - state: starve counter=0.
  - Pending loads are discarded.
- While in reset, the ready outputs are 0. They follow the arbitration rules from the first cycle after deassertion.
- Deassertion is assumed synchronised externally.

## Configuration
- `CAYDE_WB_BYPASS_EN`
  - **Defined:** adds outputs `fwd1_hit_out`/`fwd2_hit_out` (1) and `fwd_data_out` (XLEN). A hit is asserted when `wen_out`=1 and `waddr_out` equals rs1/rs2 (rs≠0). `fwd_data_out`=`wdata_out`. The output-stage hazard does not stall.
  - **Undefined:** no forwarding ports. The `stall_out` term for the output-stage hazard is: `wen_out` & (`waddr_out`==rs1 | `waddr_out`==rs2), with rs≠0.

## Structure
- `cayde_pkg`: XLEN, REG_ADDR_W=5, load funct3 enum (LB, LH, LW, LBU, LHU).
- Sub-module `cayde_load_align`: combinational; inputs data, funct3, addr_lo; outputs extended data and err.
- Top: arbiter, starve counter, scoreboard, output register.

## Test plan
- ALU rd=5 data 0xDEADBEEF, LSU idle → cycle N+1: `wen_out`=1, `waddr_out`=5, `wdata_out`=0xDEADBEEF.
- LB with raw 0x80FF0000, `addr_lo`=2 → `wdata_out`=0xFFFFFFFF. LHU with `addr_lo`=2 → 0x000080FF. LH with `addr_lo`=1 → no write, `load_err_out` pulse.
- ALU and LSU valid continuously for 5 cycles → LSU accepted for 4 cycles, ALU on the 5th, then LSU resumes.
- Issue load rd=7; decode checks rs1=7 → `stall_out`=1 until the LSU rd=7 result is accepted. Same-cycle re-issue of rd=7 keeps busy[7]=1.
- ALU rd=0 data 0x1234 → accepted, `wen_out` stays 0. Issue rd=0 → `busy_out`=0.
- Assert `rst` while a write is in the output stage and busy[3]=1 → outputs and `busy_out` are 0 immediately, with no clock edge required.
